serial_frame_router: RTL and testbench

//  Sequences the payload phase after the serial header detector fires.
//  On a one-cycle start pulse it shifts in an ADDR_W-bit channel address and a
//  LEN_W-bit payload length, MSB first. It then routes exactly LEN payload bits

---
 rtl/serial_frame_router_pkg.sv | 19 +
 rtl/serial_frame_router_if.sv | 19 +
 rtl/serial_frame_router_shift_reg.sv | 18 +
 rtl/serial_frame_router.sv | 124 ++++++++++++
 tb/tb_serial_frame_router.sv | 132 +++++++++++++
 5 files changed

// File: rtl/serial_frame_router_pkg.sv
// Shared state encoding and sizing helpers for the serial frame router.
package serial_frame_router_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Header bit counter must index up to the longer of the two header fields.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction

endpackage

// File: rtl/serial_frame_router_if.sv
// Bit-stream and per-channel output bundle of the serial frame router.
//   clk_en, start, ser_in        : stimulus side (master drives)
//   out_data, out_valid          : per-channel payload bit / strobe
//   cur_addr, busy, done         : frame status
interface serial_frame_router_if #(parameter int ADDR_W = 2);
  logic                  clk_en;
  logic                  start;
  logic                  ser_in;
  logic [2**ADDR_W-1:0]  out_data;
  logic [2**ADDR_W-1:0]  out_valid;
  logic [ADDR_W-1:0]     cur_addr;
  logic                  busy;
  logic                  done;

  modport master (output clk_en, start, ser_in,
                  input  out_data, out_valid, cur_addr, busy, done);
  modport slave  (input  clk_en, start, ser_in,
                  output out_data, out_valid, cur_addr, busy, done);
endinterface

// File: rtl/serial_frame_router_shift_reg.sv
// MSB-first serial shift-in register with synchronous clear and enable.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (beats en)
//   en       : shift one bit in from din at the LSB
//   q        : register contents
module serial_shift_reg #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= {q[W-2:0], din};
  end
endmodule

// File: rtl/serial_frame_router.sv
// Serial frame router: after a start pulse, shifts in an ADDR_W-bit channel
// address and a LEN_W-bit length (MSB first), then steers LEN payload bits
// from ser_in onto the addressed output channel and pulses done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of serial_frame_router_if (bit strobe, start,
//              serial input, per-channel outputs, status)
module serial_frame_router
  import serial_frame_router_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_frame_router_if.slave  bus
);
  localparam int NCH   = 2**ADDR_W;
  localparam int CNT_W = cnt_width(ADDR_W, LEN_W);

  state_t            ps;
  logic [CNT_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  pay_cnt;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  len_full;
  logic              frame_go;

  // Both header registers are cleared on the accepted start so a new frame
  // never inherits bits from the previous one.
  assign frame_go = bus.clk_en && (ps == S_IDLE) && bus.start;
  // Complete length value including the bit arriving this cycle.
  assign len_full = {len_reg[LEN_W-2:0], bus.ser_in};

  serial_shift_reg #(.W(ADDR_W)) u_addr (
    .clk (clk), .rst (rst), .clr (frame_go),
    .en  (bus.clk_en && (ps == S_ADDR)),
    .din (bus.ser_in), .q (addr_reg)
  );

  serial_shift_reg #(.W(LEN_W)) u_len (
    .clk (clk), .rst (rst), .clr (frame_go),
    .en  (bus.clk_en && (ps == S_LEN)),
    .din (bus.ser_in), .q (len_reg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ps      <= S_IDLE;
      bit_cnt <= '0;
      pay_cnt <= '0;
    end else if (bus.clk_en) begin
      case (ps)
        S_IDLE: if (bus.start) begin
          ps      <= S_ADDR;
          bit_cnt <= '0;
        end
        S_ADDR: begin
          if (bit_cnt == CNT_W'(ADDR_W-1)) begin
            ps      <= S_LEN;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_LEN: begin
          if (bit_cnt == CNT_W'(LEN_W-1)) begin
            bit_cnt <= '0;
            if (len_full == '0) begin
              ps <= S_DONE;
            end else begin
              ps      <= S_DATA;
              pay_cnt <= len_full;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          // Exit on the last bit; pay_cnt is never zero while in DATA.
          pay_cnt <= pay_cnt - 1'b1;
          if (pay_cnt == LEN_W'(1)) ps <= S_DONE;
        end
        S_DONE:  ps <= S_IDLE;
        default: ps <= S_IDLE;
      endcase
    end
  end

  // Moore status decode; the payload strobe also follows clk_en so a channel
  // only sees a bit on cycles that actually consume one.
  logic [NCH-1:0]    out_data_c, out_valid_c;
  logic [ADDR_W-1:0] cur_addr_c;
  logic              busy_c, done_c;

  always_comb begin
    out_data_c  = '0;
    out_valid_c = '0;
    cur_addr_c  = '0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    case (ps)
      S_ADDR, S_LEN: busy_c = 1'b1;
      S_DATA: begin
        busy_c                = 1'b1;
        cur_addr_c            = addr_reg;
        out_valid_c[addr_reg] = bus.clk_en;
        out_data_c[addr_reg]  = bus.ser_in;
      end
      S_DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        cur_addr_c = addr_reg;
      end
      default: ;
    endcase
  end

  assign bus.out_data  = out_data_c;
  assign bus.out_valid = out_valid_c;
  assign bus.cur_addr  = cur_addr_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;

endmodule

// File: tb/tb_serial_frame_router.sv
// Scoreboard bench for serial_frame_router: expected (channel, bit) pairs are
// queued as payload bits are driven and popped as strobes appear.
module tb_serial_frame_router;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 4;
  localparam int NCH    = 2**ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_frame_router_if #(.ADDR_W(ADDR_W)) bus ();

  serial_frame_router #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;
  int q_ch[$];
  int q_bit[$];

  task automatic chk(input string tag, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Inputs change 1 after posedge; outputs sampled at negedge.
  task automatic cyc(input logic en, input logic st, input logic b);
    bus.clk_en = en;
    bus.start  = st;
    bus.ser_in = b;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.out_valid[c]) begin
          chk("strobe_en", int'(bus.clk_en), 1);
          if (q_ch.size() == 0) begin
            chk("extra_strobe", c, -1);
          end else begin
            int ec, eb;
            ec = q_ch.pop_front();
            eb = q_bit.pop_front();
            chk("chan", c, ec);
            chk("data", int'(bus.out_data[c]), eb);
            chk("cur_addr", int'(bus.cur_addr), ec);
          end
        end
      end
    end
  end

  // One frame. toggle inserts an idle clk_en=0 cycle after each payload bit;
  // restart pulses start during ADDR and DATA; abort_at >= 0 resets after
  // that many payload bits.
  task automatic frame(input int a, input int l, input logic [15:0] pay,
                       input bit toggle, input bit restart, input int abort_at);
    logic [15:0] av, lv;
    av = 16'(a);
    lv = 16'(l);
    cyc(1, 1, 0);
    chk("busy_hdr", int'(bus.busy), 1);
    for (int i = 0; i < ADDR_W; i++) cyc(1, restart && i == 0, av[ADDR_W-1-i]);
    for (int i = 0; i < LEN_W; i++) begin
      if (i == LEN_W-1) chk("no_early_strobe", int'(bus.out_valid), 0);
      cyc(1, 0, lv[LEN_W-1-i]);
    end
    for (int i = 0; i < l; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_q", q_ch.size(), 0);
        return;
      end
      q_ch.push_back(a);
      q_bit.push_back(int'(pay[l-1-i]));
      cyc(1, restart && i == 1, pay[l-1-i]);
      if (toggle) cyc(0, 0, ~pay[l-1-i]);
    end
    chk("done_hi", int'(bus.done), 1);
    chk("busy_done", int'(bus.busy), 1);
    chk("addr_done", int'(bus.cur_addr), a);
    cyc(1, 0, 0);
    chk("done_lo", int'(bus.done), 0);
    chk("busy_lo", int'(bus.busy), 0);
    chk("q_empty", q_ch.size(), 0);
  endtask

  initial begin
    logic [15:0] rnd;
    bus.clk_en = 1'b1;
    bus.start  = 1'b0;
    bus.ser_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", int'(bus.busy), 0);
    chk("rst_done0", int'(bus.done), 0);
    chk("rst_valid0", int'(bus.out_valid), 0);
    chk("rst_addr0", int'(bus.cur_addr), 0);
    rst = 1'b0;
    cyc(1, 0, 0);
    chk("idle_busy", int'(bus.busy), 0);

    frame(2, 3, 16'b101, 0, 0, -1);           // basic frame
    frame(1, 0, 16'h0, 0, 0, -1);             // zero length
    rnd = 16'($urandom);
    frame(3, 15, rnd, 1, 0, -1);              // full length, gapped clk_en
    frame(1, 5, 16'b10110, 0, 1, -1);         // spurious starts
    frame(0, 5, 16'b11011, 0, 0, 2);          // reset mid-DATA
    frame(2, 5, 16'b01101, 0, 0, -1);         // fresh frame after reset
    frame(2, 2, 16'b11, 0, 0, -1);            // back-to-back pair
    frame(1, 4, 16'b1001, 0, 0, -1);

    // clk_en low must freeze everything, including start.
    cyc(0, 1, 1);
    chk("hold_busy", int'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
